// File: rtl/aes_round_ctrl.sv
// Iterative AES-128 round sequencer.
// Walks the shared round datapath and key expander through rounds 0..NR.
// All outputs are registered Moore decodes of the sequencer state.
module aes_round_ctrl #(
    parameter int unsigned NR = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       load_sel,
    output logic       state_en,
    output logic       key_en,
    output logic       last_round,
    output logic [3:0] round_idx,
    output logic [7:0] rcon,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        ROUND,
        FINAL,
        DONE
    } state_t;

    localparam logic [3:0] NR_IDX   = 4'(NR);
    localparam logic [3:0] LAST_MID = 4'(NR - 1);

    state_t     state;
    // Rcon value that the next ROUND/FINAL state will present
    logic [7:0] rc_next;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
    endfunction

    // Sequencer state and registered output decodes
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            load_sel   <= 1'b0;
            state_en   <= 1'b0;
            key_en     <= 1'b0;
            last_round <= 1'b0;
            busy       <= 1'b0;
            round_idx  <= '0;
            rcon       <= '0;
            rc_next    <= 8'h01;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        state     <= INIT;
                        in_ready  <= 1'b0;
                        load_sel  <= 1'b1;
                        state_en  <= 1'b1;
                        key_en    <= 1'b1;
                        busy      <= 1'b1;
                        round_idx <= '0;
                        rcon      <= '0;
                        rc_next   <= 8'h01;
                    end
                end
                INIT: begin
                    load_sel <= 1'b0;
                    rcon     <= rc_next;
                    rc_next  <= xtime(rc_next);
                    if (NR > 1) begin
                        state     <= ROUND;
                        round_idx <= 4'd1;
                    end else begin
                        state      <= FINAL;
                        last_round <= 1'b1;
                        round_idx  <= NR_IDX;
                    end
                end
                ROUND: begin
                    rcon      <= rc_next;
                    rc_next   <= xtime(rc_next);
                    round_idx <= round_idx + 4'd1;
                    if (round_idx == LAST_MID) begin
                        state      <= FINAL;
                        last_round <= 1'b1;
                    end
                end
                FINAL: begin
                    state      <= DONE;
                    state_en   <= 1'b0;
                    key_en     <= 1'b0;
                    last_round <= 1'b0;
                    busy       <= 1'b0;
                    out_valid  <= 1'b1;
                    rcon       <= '0;
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        round_idx <= '0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    in_ready   <= 1'b1;
                    out_valid  <= 1'b0;
                    load_sel   <= 1'b0;
                    state_en   <= 1'b0;
                    key_en     <= 1'b0;
                    last_round <= 1'b0;
                    busy       <= 1'b0;
                    round_idx  <= '0;
                    rcon       <= '0;
                    rc_next    <= 8'h01;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Self-checking bench for aes_round_ctrl built with NR = 10, 1 and 14.
module tb_aes_round_ctrl;

    localparam int unsigned NRS [3] = '{10, 1, 14};

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] in_valid_v, out_ready_v;
    logic [2:0] in_ready_v, out_valid_v, load_sel_v, state_en_v, key_en_v;
    logic [2:0] last_round_v, busy_v;
    logic [3:0] round_idx_a [3];
    logic [7:0] rcon_a [3];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    aes_round_ctrl #(.NR(10)) u_nr10 (
        .clk(clk), .rst(rst), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
        .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]), .load_sel(load_sel_v[0]),
        .state_en(state_en_v[0]), .key_en(key_en_v[0]), .last_round(last_round_v[0]),
        .round_idx(round_idx_a[0]), .rcon(rcon_a[0]), .busy(busy_v[0])
    );
    aes_round_ctrl #(.NR(1)) u_nr1 (
        .clk(clk), .rst(rst), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
        .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]), .load_sel(load_sel_v[1]),
        .state_en(state_en_v[1]), .key_en(key_en_v[1]), .last_round(last_round_v[1]),
        .round_idx(round_idx_a[1]), .rcon(rcon_a[1]), .busy(busy_v[1])
    );
    aes_round_ctrl #(.NR(14)) u_nr14 (
        .clk(clk), .rst(rst), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
        .out_valid(out_valid_v[2]), .out_ready(out_ready_v[2]), .load_sel(load_sel_v[2]),
        .state_en(state_en_v[2]), .key_en(key_en_v[2]), .last_round(last_round_v[2]),
        .round_idx(round_idx_a[2]), .rcon(rcon_a[2]), .busy(busy_v[2])
    );

    typedef struct packed {
        logic       in_ready;
        logic       out_valid;
        logic       load_sel;
        logic       state_en;
        logic       key_en;
        logic       last_round;
        logic       busy;
        logic [3:0] ridx;
        logic [7:0] rcon;
    } obs_t;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at t=%0t", name, got, exp, $time);
        end
    endtask

    // Rcon[r] from repeated GF(2^8) doubling of 01
    function automatic logic [7:0] rcon_of(input int unsigned r);
        int unsigned v = 1;
        for (int unsigned i = 1; i < r; i++) begin
            v = v * 2;
            if (v > 255) v = (v - 256) ^ 32'h1B;
        end
        return 8'(v);
    endfunction

    // Reference model: per instance, whether a block is in flight and how many
    // edges have passed since it was accepted.
    bit          act [3];
    int unsigned pos [3];
    int          cyc = 0;
    int          acc0 [$];
    bit          chk_en = 1'b0;

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                act[k] = 1'b0;
            end else if (!act[k]) begin
                if (in_valid_v[k]) begin
                    act[k] = 1'b1;
                    pos[k] = 0;
                    if (k == 0) acc0.push_back(cyc);
                end
            end else if (pos[k] > NRS[k]) begin
                if (out_ready_v[k]) act[k] = 1'b0;
            end else begin
                pos[k]++;
            end
        end
        cyc++;
    end

    function automatic obs_t expect_of(input int k);
        obs_t e;
        int unsigned nr = NRS[k];
        int unsigned p  = pos[k];
        e = '0;
        if (!act[k]) begin
            e.in_ready = 1'b1;
        end else if (p <= nr) begin
            e.busy     = 1'b1;
            e.state_en = 1'b1;
            e.key_en   = 1'b1;
            e.load_sel = (p == 0);
            e.ridx     = 4'(p);
            e.rcon     = (p == 0) ? 8'h00 : rcon_of(p);
            e.last_round = (p == nr);
        end else begin
            e.out_valid = 1'b1;
            e.ridx      = 4'(nr);
        end
        return e;
    endfunction

    // Compare every instance against the model each cycle, away from the clock edge
    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 3; k++) begin
                obs_t g;
                g = '{in_ready_v[k], out_valid_v[k], load_sel_v[k], state_en_v[k], key_en_v[k],
                      last_round_v[k], busy_v[k], round_idx_a[k], rcon_a[k]};
                chk($sformatf("model_nr%0d", NRS[k]), 32'(g), 32'(expect_of(k)));
            end
        end
    end

    typedef struct {
        int         k;
        int         gap;
        int         hold;
        int         exp_lat;
        logic [7:0] exp_last_rcon;
    } vec_t;

    vec_t tbl [6];

    task automatic run_block(input vec_t v);
        int lat;
        logic [7:0] last_rc;
        last_rc = 8'hxx;
        repeat (v.gap) @(negedge clk);
        in_valid_v[v.k] = 1'b1;
        out_ready_v[v.k] = 1'b0;
        @(negedge clk);
        in_valid_v[v.k] = 1'b0;
        lat = 0;
        while (out_valid_v[v.k] !== 1'b1 && lat < 64) begin
            if (last_round_v[v.k] === 1'b1) last_rc = rcon_a[v.k];
            @(negedge clk);
            lat++;
        end
        chk("latency", 32'(lat), 32'(v.exp_lat));
        chk("final_rcon", 32'(last_rc), 32'(v.exp_last_rcon));
        repeat (v.hold) @(negedge clk);
        out_ready_v[v.k] = 1'b1;
        @(negedge clk);
        out_ready_v[v.k] = 1'b0;
        chk("back_to_idle", 32'(in_ready_v[v.k]), 32'd1);
    endtask

    initial begin
        int n;
        bit seen;
        tbl[0] = '{0, 0, 0, 11, 8'h36};
        tbl[1] = '{0, 3, 5, 11, 8'h36};
        tbl[2] = '{1, 0, 0, 2, 8'h01};
        tbl[3] = '{1, 2, 3, 2, 8'h01};
        tbl[4] = '{2, 0, 0, 15, 8'h4D};
        tbl[5] = '{2, 1, 2, 15, 8'h4D};

        rst = 1'b1;
        in_valid_v = '0;
        out_ready_v = '0;
        @(posedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_in_ready", 32'(in_ready_v), 32'h7);
        chk("reset_rcon", 32'(rcon_a[0]), 32'h0);

        for (int i = 0; i < 6; i++) run_block(tbl[i]);

        // DONE stall: out_ready low for 5 cycles with a new block waiting
        in_valid_v[0] = 1'b1;
        @(negedge clk);
        n = 0;
        while (out_valid_v[0] !== 1'b1 && n < 40) begin @(negedge clk); n++; end
        chk("stall_reach_done", 32'(out_valid_v[0]), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_out_valid", 32'(out_valid_v[0]), 32'd1);
            chk("stall_en", 32'({state_en_v[0], key_en_v[0]}), 32'd0);
            chk("stall_in_ready", 32'(in_ready_v[0]), 32'd0);
        end
        in_valid_v[0] = 1'b0;
        out_ready_v[0] = 1'b1;
        @(negedge clk);
        out_ready_v[0] = 1'b0;
        chk("release_idle", 32'({in_ready_v[0], out_valid_v[0]}), 32'h2);

        // Back-to-back blocks: one accept every NR+3 cycles
        acc0.delete();
        in_valid_v[0] = 1'b1;
        out_ready_v[0] = 1'b1;
        repeat (45) @(negedge clk);
        in_valid_v[0] = 1'b0;
        repeat (20) @(negedge clk);
        out_ready_v[0] = 1'b0;
        chk("b2b_accepts", 32'(acc0.size() >= 3), 32'd1);
        for (int i = 0; i + 1 < acc0.size(); i++)
            chk("b2b_spacing", 32'(acc0[i+1] - acc0[i]), 32'd13);

        // Reset mid-flight at round 5: block discarded, no out_valid
        in_valid_v[0] = 1'b1;
        @(negedge clk);
        in_valid_v[0] = 1'b0;
        n = 0;
        while (round_idx_a[0] !== 4'd5 && n < 30) begin @(negedge clk); n++; end
        chk("reach_round5", 32'(round_idx_a[0]), 32'd5);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midreset_state", 32'({in_ready_v[0], busy_v[0], round_idx_a[0]}), 32'h20);
        out_ready_v[0] = 1'b1;
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid_v[0] === 1'b1) seen = 1'b1;
        end
        out_ready_v[0] = 1'b0;
        chk("midreset_no_out", 32'(seen), 32'd0);

        // Random handshakes and occasional resets against the model
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            in_valid_v  = 3'($urandom);
            out_ready_v = 3'($urandom);
            rst = ($urandom_range(0, 63) == 0);
        end
        @(negedge clk);
        rst = 1'b0;
        in_valid_v = '0;
        out_ready_v = '0;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
